immediate_extender: RTL and testbench

//  RV32I immediate generator in the decode stage: takes instruction bits [31:6] plus a format code, builds the 32-bit immediate.

---
 rtl/imm_ext_pkg.sv | 22 ++
 rtl/imm_ext_comb.sv | 59 +++++
 rtl/immediate_extender.sv | 36 +++
 tb/tb_immediate_extender.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types for the RV32I immediate extender: format select encoding and datapath width.
// The optional CSR zimm format is enabled by defining IMM_EXT_ZIMM_EN.
package imm_ext_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_SH   = 3'd5,
    FMT_Z    = 3'd6,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  function automatic imm_fmt_e to_fmt(input logic [2:0] raw);
    return imm_fmt_e'(raw);
  endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational RV32I immediate decode: selects instruction fields by format and sign/zero extends.
// Format FMT_Z returns the CSR zimm only when IMM_EXT_ZIMM_EN is defined; otherwise it reads as zero.
module imm_ext_comb
  import imm_ext_pkg::*;
(
  input  logic [25:0]     i_imm_in,
  input  logic [2:0]      i_format,
  output logic [XLEN-1:0] o_imm
);

  // Instruction view ins[31:7]; ins[6] is carried in the port but no format uses it.
  logic [31:7] w_ins;
  logic        w_unused_ins6;
  imm_fmt_e    w_fmt;

  assign w_ins         = i_imm_in[25:1];
  assign w_unused_ins6 = i_imm_in[0];
  assign w_fmt         = to_fmt(i_format);

  // Field gather and extension for each immediate format.
  always_comb begin
    o_imm = {XLEN{1'b0}};
    case (w_fmt)
      FMT_I: begin
        o_imm = {{20{w_ins[31]}}, w_ins[31:20]};
      end
      FMT_S: begin
        o_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      end
      FMT_B: begin
        o_imm = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      end
      FMT_U: begin
        o_imm = {w_ins[31:12], 12'h000};
      end
      FMT_J: begin
        o_imm = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      end
      FMT_SH: begin
        // ins[30] distinguishes SRAI from SRLI and is not part of the shift amount.
        o_imm = {27'd0, w_ins[24:20]};
      end
      FMT_Z: begin
`ifdef IMM_EXT_ZIMM_EN
        o_imm = {27'd0, w_ins[19:15]};
`else
        o_imm = {XLEN{1'b0}};
`endif
      end
      FMT_NONE: begin
        o_imm = {XLEN{1'b0}};
      end
      default: begin
        o_imm = {XLEN{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/immediate_extender.sv
// Decode-stage immediate generator: combinational extension followed by a stall-holdable output register.
// Define IMM_EXT_ZIMM_EN to make format 3'd6 produce the CSR zimm instead of zero.
module immediate_extender #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [25:0]     Imm_in,
  input  logic [2:0]      Format,
  output logic [XLEN-1:0] Imm_out
);

  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] r_imm;

  imm_ext_comb u_comb (
    .i_imm_in (Imm_in),
    .i_format (Format),
    .o_imm    (w_imm)
  );

  // Output register: reset wins over enable; en low holds the value during a decode stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_imm <= {XLEN{1'b0}};
    end else if (en) begin
      r_imm <= w_imm;
    end else begin
      r_imm <= r_imm;
    end
  end

  assign Imm_out = r_imm;

endmodule

// File: tb/tb_immediate_extender.sv
// Scoreboard bench for immediate_extender: directed RV32I encodings plus randomized traffic.
module tb_immediate_extender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [25:0] Imm_in;
  logic [2:0]  Format;
  logic [31:0] Imm_out;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_q = 32'd0;

  immediate_extender #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .Imm_in  (Imm_in),
    .Format  (Format),
    .Imm_out (Imm_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sext(input int v, input int bits);
    int r;
    r = v;
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return 32'(r);
  endfunction

  // Immediate value built from the ISA field definitions with plain arithmetic.
  function automatic logic [31:0] ref_imm(input logic [31:0] instr, input logic [2:0] fmt);
    int v;
    case (fmt)
      3'd0: return sext(int'(instr[31:20]), 12);
      3'd1: begin
        v = int'(instr[31:25]) * 32 + int'(instr[11:7]);
        return sext(v, 12);
      end
      3'd2: begin
        v = int'(instr[31]) * 4096 + int'(instr[7]) * 2048
          + int'(instr[30:25]) * 32 + int'(instr[11:8]) * 2;
        return sext(v, 13);
      end
      3'd3: return instr & 32'hFFFFF000;
      3'd4: begin
        v = int'(instr[31]) * 1048576 + int'(instr[19:12]) * 4096
          + int'(instr[20]) * 2048 + int'(instr[30:21]) * 2;
        return sext(v, 21);
      end
      3'd5: return 32'(instr[24:20]);
`ifdef IMM_EXT_ZIMM_EN
      3'd6: return 32'(instr[19:15]);
`else
      3'd6: return 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Apply one cycle of inputs and queue the register value expected after the next edge.
  task automatic drive(input logic r, input logic e, input logic [31:0] instr,
                       input logic [2:0] fmt, input logic use_const,
                       input logic [31:0] cval, input string name);
    exp_t x;
    @(negedge clk);
    rst_n  = r;
    en     = e;
    Imm_in = instr[31:6];
    Format = fmt;
    if (!r)             model_q = 32'd0;
    else if (!e)        model_q = model_q;
    else if (use_const) model_q = cval;
    else                model_q = ref_imm(instr, fmt);
    x.val  = model_q;
    x.name = name;
    exp_q.push_back(x);
  endtask

  // Monitor: one register result per edge, compared against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Imm_out !== e.val) begin
          errors++;
          $display("FAIL %s: Imm_out=%h expected %h", e.name, Imm_out, e.val);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r32;
    rst_n  = 1'b0;
    en     = 1'b0;
    Imm_in = 26'd0;
    Format = 3'd0;

    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, "reset0");
    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0, "reset1");
    drive(1'b0, 1'b1, 32'hFFF00093, 3'd0, 1'b1, 32'h0, "reset_over_en0");
    drive(1'b0, 1'b1, 32'hFFF00093, 3'd0, 1'b1, 32'h0, "reset_over_en1");

    drive(1'b1, 1'b1, 32'hFFF00093, 3'd0, 1'b1, 32'hFFFFFFFF, "I_addi");
    drive(1'b1, 1'b1, 32'h40305093, 3'd5, 1'b1, 32'h00000003, "SH_srai");
    drive(1'b1, 1'b1, 32'h0020A423, 3'd1, 1'b1, 32'h00000008, "S_sw");
    drive(1'b1, 1'b1, 32'hFE000CE3, 3'd2, 1'b1, 32'hFFFFFFF8, "B_beq");
    drive(1'b1, 1'b1, 32'h123450B7, 3'd3, 1'b1, 32'h12345000, "U_lui");
    drive(1'b1, 1'b1, 32'hFFDFF06F, 3'd4, 1'b1, 32'hFFFFFFFC, "J_jal");
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 3'd7, 1'b1, 32'h00000000, "fmt7");
`ifdef IMM_EXT_ZIMM_EN
    drive(1'b1, 1'b1, 32'h000FD073, 3'd6, 1'b1, 32'h0000001F, "Z_zimm");
`else
    drive(1'b1, 1'b1, 32'h000FD073, 3'd6, 1'b1, 32'h00000000, "Z_disabled");
`endif

    // Stall: hold an I-type result while inputs change, then release.
    drive(1'b1, 1'b1, 32'h7FF00093, 3'd0, 1'b1, 32'h000007FF, "stall_load");
    for (int i = 0; i < 3; i++) begin
      r32 = $urandom;
      drive(1'b1, 1'b0, r32, 3'($urandom_range(0, 7)), 1'b0, 32'h0, "stall_hold");
    end
    drive(1'b1, 1'b1, 32'h80000093, 3'd0, 1'b1, 32'hFFFFF800, "stall_release");

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      r32 = $urandom;
      drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), r32,
            3'($urandom_range(0, 7)), 1'b0, 32'h0, "random");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue depth=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
